// File: rtl/mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// =============================================================================
// mem_arbiter : IF / LS arbiter for a single-port word memory, with a
//               starvation guard and a one-cycle tagged response pipeline.
// Revision    : 1.0
// =============================================================================
module mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [31:0]       ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [31:0]       ls_rdata,
  output logic              ls_err,
  output logic              mem_W,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_dout,
  input  logic [31:0]       mem_din
);

  localparam logic [1:0]       OWN_NONE   = 2'd0;
  localparam logic [1:0]       OWN_IF     = 2'd1;
  localparam logic [1:0]       OWN_LS     = 2'd2;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [1:0]       owner_q, owner_d;
  logic             err_q, err_d;
  logic             we_q, we_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             if_win;
  logic             addr_ok;
  logic [31:0]      sel_addr;
  logic [31:0]      rsp_data;

  // Grants are held off while in reset so no store can leak into memory.
  always_comb begin
    if_win   = resetn && if_req && (!ls_req || (starve_q == STARVE_LIM));
    if_gnt   = if_win;
    ls_gnt   = resetn && ls_req && !if_win;
    sel_addr = ls_gnt ? ls_addr : if_addr;
    addr_ok  = (sel_addr[1:0] == 2'b00) && ((sel_addr >> (ADDR_W + 2)) == 32'd0);
    mem_addr = sel_addr[ADDR_W+1:2];
    mem_W    = ls_gnt && ls_we && addr_ok;
    mem_dout = ls_wdata;
  end

  always_comb begin
    owner_d  = OWN_NONE;
    err_d    = 1'b0;
    we_d     = 1'b0;
    starve_d = '0;
    if (if_gnt) begin
      owner_d = OWN_IF;
      err_d   = !addr_ok;
    end else if (ls_gnt) begin
      owner_d = OWN_LS;
      err_d   = !addr_ok;
      we_d    = ls_we;
    end
    if (if_req && !if_gnt) begin
      starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner_q  <= OWN_NONE;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      starve_q <= '0;
    end else begin
      owner_q  <= owner_d;
      err_q    <= err_d;
      we_q     <= we_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    if_rvalid = (owner_q == OWN_IF);
    ls_rvalid = (owner_q == OWN_LS);
    rsp_data  = (err_q || we_q) ? 32'd0 : mem_din;
    if_rdata  = if_rvalid ? rsp_data : 32'd0;
    ls_rdata  = ls_rvalid ? rsp_data : 32'd0;
    if_err    = if_rvalid && err_q;
    ls_err    = ls_rvalid && err_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// =============================================================================
// tb_mem_arbiter : directed + random bench with a transaction-level model.
// Revision       : 1.0
// =============================================================================
module tb_mem_arbiter;
  localparam int ADDR_W     = 16;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              resetn;
  logic              if_req, ls_req, ls_we;
  logic [31:0]       if_addr, ls_addr, ls_wdata;
  logic              if_gnt, if_rvalid, if_err, ls_gnt, ls_rvalid, ls_err;
  logic [31:0]       if_rdata, ls_rdata, mem_dout, mem_din;
  logic              mem_W;
  logic [ADDR_W-1:0] mem_addr;

  mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX), .CNT_W(3)) dut (
    .clk(clk), .resetn(resetn),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_W(mem_W), .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din)
  );

  always #5 clk = ~clk;

  // Environment memory: registered read, one cycle latency.
  logic [31:0] ram [0:(1<<ADDR_W)-1];
  initial for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 32'd0;
  always @(posedge clk) begin
    if (mem_W) ram[mem_addr] <= mem_dout;
    mem_din <= ram[mem_addr];
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: byte-addressed memory image, starvation count,
  // and the one response expected on the following cycle.
  logic [31:0] model_mem [int];
  int          m_starve = 0;
  bit          p_valid = 0, p_is_if = 0, p_err = 0;
  logic [31:0] p_data = 0;
  bit          e_if_g = 0, e_ls_g = 0;

  function automatic bit legal(input logic [31:0] a);
    longint lim;
    lim = 4 * (longint'(1) << ADDR_W);
    return (a % 4 == 0) && (longint'(a) < lim);
  endfunction

  always @(negedge clk) begin : cmp
    logic [31:0] a;
    bit          ok, ew;
    if (!resetn) begin
      chk("rst_if_gnt", if_gnt, 0);     chk("rst_ls_gnt", ls_gnt, 0);
      chk("rst_if_rvalid", if_rvalid, 0); chk("rst_ls_rvalid", ls_rvalid, 0);
      chk("rst_if_err", if_err, 0);     chk("rst_ls_err", ls_err, 0);
      chk("rst_if_rdata", if_rdata, 0); chk("rst_ls_rdata", ls_rdata, 0);
      chk("rst_mem_W", mem_W, 0);
      p_valid = 0; m_starve = 0; e_if_g = 0; e_ls_g = 0;
    end else begin
      e_if_g = if_req && (!ls_req || m_starve >= STARVE_MAX);
      e_ls_g = ls_req && !e_if_g;
      chk("if_gnt", if_gnt, e_if_g);
      chk("ls_gnt", ls_gnt, e_ls_g);
      chk("if_rvalid", if_rvalid, p_valid && p_is_if);
      chk("ls_rvalid", ls_rvalid, p_valid && !p_is_if);
      if (p_valid && p_is_if) begin
        chk("if_rdata", if_rdata, p_data); chk("if_err", if_err, p_err);
      end
      if (p_valid && !p_is_if) begin
        chk("ls_rdata", ls_rdata, p_data); chk("ls_err", ls_err, p_err);
      end
      a  = e_ls_g ? ls_addr : if_addr;
      ok = legal(a);
      ew = e_ls_g && ls_we && ok;
      chk("mem_W", mem_W, ew);
      if ((e_if_g || e_ls_g) && ok) chk("mem_addr", mem_addr, a / 4);
      if (ew) chk("mem_dout", mem_dout, ls_wdata);
      p_valid = e_if_g || e_ls_g;
      p_is_if = e_if_g;
      p_err   = !ok;
      if (!ok || (e_ls_g && ls_we)) p_data = 0;
      else p_data = model_mem.exists(int'(a)) ? model_mem[int'(a)] : 32'd0;
      if (ew) model_mem[int'(a)] = ls_wdata;
      if (if_req && !e_if_g) m_starve = (m_starve >= STARVE_MAX) ? STARVE_MAX : m_starve + 1;
      else m_starve = 0;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rnd_addr();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
    if (r == 1) return 32'h0004_0000 | {26'd0, 4'($urandom_range(0, 15)), 2'b00};
    return {26'd0, 4'($urandom_range(0, 15)), 2'b00};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [9:0]  pat;
    logic [31:0] vals [3];
    resetn = 0; if_req = 1; ls_req = 1; ls_we = 0;
    if_addr = 0; ls_addr = 0; ls_wdata = 0;
    vals[0] = 32'h1111_0001; vals[1] = 32'h2222_0002; vals[2] = 32'h3333_0003;

    // Reset with both requests pending, then continuous contention.
    @(negedge clk);
    chk("t1_ls_rvalid", ls_rvalid, 0); chk("t1_if_rvalid", if_rvalid, 0);
    chk("t1_mem_W", mem_W, 0);         chk("t1_ls_err", ls_err, 0);
    step(); resetn = 1;
    pat = 10'b10000_10000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("t3_if_gnt_%0d", i), if_gnt, pat[i]);
      chk($sformatf("t3_ls_gnt_%0d", i), ls_gnt, !pat[i]);
      step();
    end

    // Store then read back on the very next cycle.
    if_req = 0; ls_req = 1; ls_we = 1; ls_addr = 32'h10; ls_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("t2_ls_gnt", ls_gnt, 1); chk("t2_mem_W", mem_W, 1); chk("t2_mem_addr", mem_addr, 4);
    step(); ls_req = 0; ls_we = 0; if_req = 1; if_addr = 32'h10;
    @(negedge clk);
    chk("t2_ls_rvalid", ls_rvalid, 1); chk("t2_ls_rdata", ls_rdata, 0); chk("t2_if_gnt", if_gnt, 1);
    step(); if_req = 0;
    @(negedge clk);
    chk("t2_if_rvalid", if_rvalid, 1); chk("t2_if_rdata", if_rdata, 32'hDEADBEEF);
    step();

    // Misaligned and out-of-range accesses.
    ls_req = 1; ls_we = 0; ls_addr = 32'h13;
    @(negedge clk);
    chk("t4_gnt_mis", ls_gnt, 1); chk("t4_memW_mis", mem_W, 0);
    step(); ls_addr = 32'h0004_0000;
    @(negedge clk);
    chk("t4_rvalid_mis", ls_rvalid, 1); chk("t4_err_mis", ls_err, 1); chk("t4_rdata_mis", ls_rdata, 0);
    chk("t4_gnt_oor", ls_gnt, 1);
    step(); ls_we = 1; ls_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("t4_memW_oor_st", mem_W, 0); chk("t4_err_oor", ls_err, 1); chk("t4_rdata_oor", ls_rdata, 0);
    step(); ls_req = 0; ls_we = 0;
    @(negedge clk);
    chk("t4_err_oor_st", ls_err, 1); chk("t4_rdata_oor_st", ls_rdata, 0);
    step();

    // Preload three words, then back-to-back instruction fetches.
    for (int i = 0; i < 3; i++) begin
      ls_req = 1; ls_we = 1; ls_addr = 32'(4 * i); ls_wdata = vals[i];
      @(negedge clk); step();
    end
    ls_req = 0; ls_we = 0;
    for (int i = 0; i < 3; i++) begin
      if_req = 1; if_addr = 32'(4 * i);
      @(negedge clk);
      chk($sformatf("t5_if_gnt_%0d", i), if_gnt, 1);
      if (i > 0) begin
        chk($sformatf("t5_rvalid_%0d", i - 1), if_rvalid, 1);
        chk($sformatf("t5_rdata_%0d", i - 1), if_rdata, vals[i - 1]);
      end
      step();
    end
    if_req = 0;
    @(negedge clk);
    chk("t5_rvalid_2", if_rvalid, 1); chk("t5_rdata_2", if_rdata, vals[2]);
    step();

    // Reset right after a grant; starvation count must restart.
    if_req = 1; ls_req = 1; ls_we = 0; ls_addr = 32'h10; if_addr = 32'h0;
    @(negedge clk); step();
    @(negedge clk); step();
    resetn = 0;
    @(negedge clk);
    chk("t6_ls_rvalid", ls_rvalid, 0); chk("t6_if_rvalid", if_rvalid, 0);
    step(); resetn = 1;
    @(negedge clk);
    chk("t6_ls_rvalid_rel", ls_rvalid, 0); chk("t6_if_rvalid_rel", if_rvalid, 0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("t6_if_gnt_%0d", i), if_gnt, (i == 4));
      step();
    end

    // Randomized traffic obeying the hold-until-grant protocol.
    for (int n = 0; n < 2000; n++) begin
      resetn = ($urandom_range(0, 199) != 0);
      if (!if_req || e_if_g) begin
        if_req  = ($urandom_range(0, 2) != 0);
        if_addr = rnd_addr();
      end
      if (!ls_req || e_ls_g) begin
        ls_req   = ($urandom_range(0, 2) != 0);
        ls_we    = 1'($urandom_range(0, 1));
        ls_addr  = rnd_addr();
        ls_wdata = $urandom;
      end
      @(negedge clk);
      step();
    end

    resetn = 1; if_req = 0; ls_req = 0;
    @(negedge clk);
    step();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
